alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: instr_valid  input  1  instruction offered.
REQ-004 SHALL have port: instr_ready  output  1  high exactly when state is IDLE.
REQ-005 SHALL have port: instr  input  16  fields [15:12] op, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm.
REQ-006 SHALL have port: alu_a  output  8  registered operand A to external ALU.
REQ-007 SHALL have port: alu_b  output  8  registered operand B to external ALU.
REQ-008 SHALL have port: alu_ci  output  1  ALU carry-in; constant 0.
REQ-009 SHALL have port: alu_mode  output  4  registered ALU mode.
REQ-010 SHALL have port: alu_s  input  8  ALU result; combinational, valid one cycle after operands change.
REQ-011 SHALL have port: alu_cout  input  1  ALU carry-out.
REQ-012 SHALL have port: result  output  8  last written register value.
REQ-013 SHALL have port: carry_flag  output  1  registered carry.
REQ-014 SHALL have port: zero_flag  output  1  registered zero.
REQ-015 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port: illegal  output  1  one-cycle pulse on undefined op.
REQ-017 SHALL have port: rd_sel  input  2  register readback select.
REQ-018 SHALL have port: rd_data  output  8  combinational R[rd_sel].

Function
REQ-019 SHALL contain register file R0..R3, 8 bits each.
REQ-020 SHALL decode op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOT (A only), 0101 LDI; 0110-1111 illegal.
REQ-021 SHALL implement FSM states IDLE, DECODE, EXEC.
REQ-022 SHALL accept instr at edge E0 where instr_valid and instr_ready are both high; capture instr; IDLE->DECODE.
REQ-023 SHALL, in IDLE without handshake, remain IDLE with no state change.
REQ-024 SHALL, at edge E1 leaving DECODE for ops 0000-0100: alu_a<=R[rs1], alu_b<=R[rs2], alu_mode<=op; DECODE->EXEC.
REQ-025 SHALL, at edge E2 leaving EXEC: R[rd]<=alu_s, result<=alu_s, zero_flag<=(alu_s==0), done<=1; ->IDLE.
REQ-026 SHALL update carry_flag<=alu_cout at E2 only for ADD/SUB; AND/OR/NOT leave it unchanged.
REQ-027 SHALL, at E1 for LDI: R[rd]<=imm, result<=imm, zero_flag<=(imm==0), done<=1, carry unchanged; ->IDLE.
REQ-028 SHALL, at E1 for illegal op: illegal<=1, no register/flag/ALU-output change; ->IDLE.
REQ-029 SHALL hold alu_a/alu_b/alu_mode stable between ALU instructions.
REQ-030 SHALL give latency: done high in cycle after E2 (ALU ops), after E1 (LDI).
REQ-031 SHALL allow back-to-back: cycle with done high is IDLE, so a new instruction is accepted that cycle.
REQ-032 SHALL ignore instr_valid while not IDLE (no buffering).
REQ-033 SHALL read operands at E1, before the E2 write, so rd equal to rs1/rs2 is legal.
REQ-034 SHALL update rd_data in the cycle after any write.

Reset
REQ-035 SHALL, while rst_n low, force R0..R3, alu_a, alu_b, alu_mode, result, flags, done, illegal to 0 and state to IDLE, independent of clk.
REQ-036 SHALL abort any in-flight instruction on reset without done or register write.
REQ-037 SHALL keep alu_ci at 0 under reset and at all times.

Verification
REQ-038 SHALL cover: reset pulse -> all outputs 0, instr_ready=1 first cycle after release.
REQ-039 SHALL cover: LDI R1,0x3C; LDI R2,0xC4; ADD R3,R1,R2 with ALU model (s=00, cout=1) -> alu_a=3C, alu_b=C4, mode=0000, R3=00, zero=1, carry=1, done 2 cycles after accept.
REQ-040 SHALL cover: SUB R0,R1,R2 with model s=78, cout=0 -> R0=78, carry=0, zero=0; then AND R0,R0,R0 model s=78 -> carry stays 0.
REQ-041 SHALL cover: op 0111 accepted -> illegal high one cycle after accept, R0..R3 and flags unchanged, done stays 0.
REQ-042 SHALL cover: instr_valid held high across an ADD -> second instr accepted in done cycle, never during DECODE/EXEC.
REQ-043 SHALL cover: rst_n low during EXEC -> no done, R0..R3=00, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Instruction offer channel between an issuing master and the alu_sequencer.
// A transfer happens on the rising edge where instr_valid and instr_ready are both high.
interface alu_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer driving an external combinational ALU
// from a 4 x 8-bit register file; LDI and illegal ops finish in DECODE.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  alu_sequencer_if.slave bus,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_ci,
  output logic [3:0]  alu_mode,
  input  logic [7:0]  alu_s,
  input  logic        alu_cout,
  output logic [7:0]  result,
  output logic        carry_flag,
  output logic        zero_flag,
  output logic        done,
  output logic        illegal,
  input  logic [1:0]  rd_sel,
  output logic [7:0]  rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;

  state_t      state;
  logic [15:0] ir;
  logic [7:0]  regs [4];

  logic [3:0]  op;
  logic [1:0]  rd;
  logic [1:0]  rs1;
  logic [1:0]  rs2;
  logic [7:0]  imm;

  assign op  = ir[15:12];
  assign rd  = ir[11:10];
  assign rs1 = ir[9:8];
  assign rs2 = ir[7:6];
  assign imm = ir[7:0];

  assign bus.instr_ready = (state == S_IDLE);
  assign alu_ci          = 1'b0;
  assign rd_data         = regs[rd_sel];

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what lets rd alias rs1/rs2 safely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ir         <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mode   <= '0;
      result     <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      // NOTE: the register file must read back as zero after reset, so it is
      // built from resettable flops rather than an inferred RAM.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op <= OP_NOT) begin
            alu_a    <= regs[rs1];
            alu_b    <= regs[rs2];
            alu_mode <= op;
            state    <= S_EXEC;
          end else if (op == OP_LDI) begin
            regs[rd]  <= imm;
            result    <= imm;
            zero_flag <= (imm == 8'h00);
            done      <= 1'b1;
            state     <= S_IDLE;
          end else begin
            illegal <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_EXEC: begin
          // alu_mode still holds the op, so it decides whether carry is live.
          regs[rd]  <= alu_s;
          result    <= alu_s;
          zero_flag <= (alu_s == 8'h00);
          if (alu_mode == OP_ADD || alu_mode == OP_SUB) carry_flag <= alu_cout;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized checks of alu_sequencer against an instruction-level
// model; the external ALU is a behavioural adder/logic unit inside the bench.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_a, alu_b, alu_s, result, rd_data;
  logic [3:0] alu_mode;
  logic       alu_ci, alu_cout, carry_flag, zero_flag, done, illegal;
  logic [1:0] rd_sel;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ci     (alu_ci),
    .alu_mode   (alu_mode),
    .alu_s      (alu_s),
    .alu_cout   (alu_cout),
    .result     (result),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .done       (done),
    .illegal    (illegal),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural ALU: returns {cout, s}; SUB reports carry as "no borrow".
  function automatic logic [8:0] ref_alu(input logic [3:0] mode, input logic [7:0] a, input logic [7:0] b);
    case (mode)
      4'h0:    return {1'b0, a} + {1'b0, b};
      4'h1:    return {(a >= b), 8'(a - b)};
      4'h2:    return {1'b0, a & b};
      4'h3:    return {1'b0, a | b};
      4'h4:    return {1'b0, ~a};
      default: return 9'h000;
    endcase
  endfunction

  assign {alu_cout, alu_s} = ref_alu(alu_mode, alu_a, alu_b);

  // Instruction-level model of architectural state.
  logic [7:0] m_r [4];
  logic [7:0] m_result, m_a, m_b;
  logic [3:0] m_mode;
  logic       m_carry, m_zero;

  function automatic logic [15:0] alu_op(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 6'b000000};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {4'h5, rd, 2'b00, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_result = 8'h00; m_a = 8'h00; m_b = 8'h00; m_mode = 4'h0;
    m_carry = 1'b0; m_zero = 1'b0;
  endtask

  // Called right at a falling edge; four 1 ns reads finish before the next rise.
  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), 32'(rd_data), 32'(m_r[i]));
    end
  endtask

  task automatic check_arch(input string tag);
    check({tag, "_result"}, 32'(result), 32'(m_result));
    check({tag, "_carry"}, 32'(carry_flag), 32'(m_carry));
    check({tag, "_zero"}, 32'(zero_flag), 32'(m_zero));
    check({tag, "_alu_a"}, 32'(alu_a), 32'(m_a));
    check({tag, "_alu_b"}, 32'(alu_b), 32'(m_b));
    check({tag, "_alu_mode"}, 32'(alu_mode), 32'(m_mode));
    check({tag, "_alu_ci"}, 32'(alu_ci), 32'(0));
  endtask

  // Offer one instruction from IDLE and follow it to completion.
  task automatic run_instr(input logic [15:0] ins, input string tag);
    logic [3:0] op;
    logic [8:0] r;
    op = ins[15:12];
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(bus.instr_ready), 32'(1));
    check({tag, "_idle_done"}, 32'(done), 32'(0));
    check({tag, "_idle_illegal"}, 32'(illegal), 32'(0));
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check({tag, "_decode_ready"}, 32'(bus.instr_ready), 32'(0));
    check({tag, "_decode_done"}, 32'(done), 32'(0));
    @(negedge clk);
    if (op <= 4'h4) begin
      m_a = m_r[ins[9:8]]; m_b = m_r[ins[7:6]]; m_mode = op;
      check({tag, "_exec_ready"}, 32'(bus.instr_ready), 32'(0));
      check({tag, "_exec_done"}, 32'(done), 32'(0));
      check({tag, "_exec_alu_a"}, 32'(alu_a), 32'(m_a));
      check({tag, "_exec_alu_b"}, 32'(alu_b), 32'(m_b));
      check({tag, "_exec_mode"}, 32'(alu_mode), 32'(m_mode));
      @(negedge clk);
      r = ref_alu(op, m_a, m_b);
      m_r[ins[11:10]] = r[7:0];
      m_result = r[7:0];
      m_zero = (r[7:0] == 8'h00);
      if (op <= 4'h1) m_carry = r[8];
    end else if (op == 4'h5) begin
      m_r[ins[11:10]] = ins[7:0];
      m_result = ins[7:0];
      m_zero = (ins[7:0] == 8'h00);
    end
    check({tag, "_done"}, 32'(done), 32'(op <= 4'h5));
    check({tag, "_illegal"}, 32'(illegal), 32'(op > 4'h5));
    check({tag, "_end_ready"}, 32'(bus.instr_ready), 32'(1));
    check_arch(tag);
    check_regs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    rd_sel = 2'd0;
    model_reset();

    // Reset pulse: outputs forced low without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_done", 32'(done), 32'(0));
    check("rst_illegal", 32'(illegal), 32'(0));
    check_arch("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_regs("rst");
    @(negedge clk);
    check("rst_ready_after", 32'(bus.instr_ready), 32'(1));

    // LDI R1,3C; LDI R2,C4; ADD R3,R1,R2 -> 00 with carry.
    run_instr(ldi(2'd1, 8'h3C), "ldi_r1");
    run_instr(ldi(2'd2, 8'hC4), "ldi_r2");
    run_instr(alu_op(4'h0, 2'd3, 2'd1, 2'd2), "add_r3");
    check("add_r3_const_zero", 32'(zero_flag), 32'(1));
    check("add_r3_const_carry", 32'(carry_flag), 32'(1));
    check("add_r3_const_a", 32'(alu_a), 32'(8'h3C));

    // SUB R0,R1,R2 -> 78 no carry; AND R0,R0,R0 leaves carry alone.
    run_instr(alu_op(4'h1, 2'd0, 2'd1, 2'd2), "sub_r0");
    check("sub_r0_const_result", 32'(result), 32'(8'h78));
    run_instr(alu_op(4'h2, 2'd0, 2'd0, 2'd0), "and_r0");
    check("and_r0_const_carry", 32'(carry_flag), 32'(0));

    // Undefined op 0111.
    run_instr(16'h7ABC, "illegal_7");

    // instr_valid held high across an ADD: the follow-on LDI waits for the done cycle.
    @(negedge clk);
    check("b2b_ready0", 32'(bus.instr_ready), 32'(1));
    bus.instr_valid = 1'b1;
    bus.instr = alu_op(4'h0, 2'd2, 2'd1, 2'd1);
    @(negedge clk);
    bus.instr = ldi(2'd0, 8'h55);
    check("b2b_decode_ready", 32'(bus.instr_ready), 32'(0));
    @(negedge clk);
    check("b2b_exec_ready", 32'(bus.instr_ready), 32'(0));
    rd_sel = 2'd0;
    #1 check("b2b_exec_r0", 32'(rd_data), 32'(m_r[0]));
    @(negedge clk);
    m_a = m_r[1]; m_b = m_r[1]; m_mode = 4'h0;
    begin
      logic [8:0] r;
      r = ref_alu(4'h0, m_a, m_b);
      m_r[2] = r[7:0]; m_result = r[7:0]; m_zero = (r[7:0] == 8'h00); m_carry = r[8];
    end
    check("b2b_add_done", 32'(done), 32'(1));
    check("b2b_add_ready", 32'(bus.instr_ready), 32'(1));
    check_arch("b2b_add");
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("b2b_ldi_decode_ready", 32'(bus.instr_ready), 32'(0));
    check("b2b_ldi_decode_done", 32'(done), 32'(0));
    @(negedge clk);
    m_r[0] = 8'h55; m_result = 8'h55; m_zero = 1'b0;
    check("b2b_ldi_done", 32'(done), 32'(1));
    check_arch("b2b_ldi");
    check_regs("b2b_ldi");

    // Reset asserted during EXEC aborts the ADD.
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = alu_op(4'h0, 2'd1, 2'd1, 2'd2);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("abort_exec_ready", 32'(bus.instr_ready), 32'(0));
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_done", 32'(done), 32'(0));
    check_arch("abort");
    @(negedge clk);
    check("abort_done_later", 32'(done), 32'(0));
    rst_n = 1'b1;
    check_regs("abort");
    @(negedge clk);
    check("abort_ready_after", 32'(bus.instr_ready), 32'(1));
    check("abort_done_after", 32'(done), 32'(0));

    // Randomized instruction stream with idle gaps.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      logic [15:0] ins;
      int pick;
      pick = int'($urandom_range(0, 8));
      op = (pick <= 5) ? 4'(pick) : 4'($urandom_range(6, 15));
      ins = {op, 12'($urandom)};
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("gap_ready", 32'(bus.instr_ready), 32'(1));
        check("gap_result", 32'(result), 32'(m_result));
      end
      run_instr(ins, $sformatf("rnd%0d_op%0h", n, op));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
